// File: rtl/riscm_pkg.sv
// Shared Simple RISC Machine definitions: opcodes, IR field positions,
// register-select codes and the fetch-unit state encoding.
package riscm_pkg;

  localparam int unsigned IR_W = 16;

  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 13;
  localparam int unsigned OP_MSB    = 12;
  localparam int unsigned OP_LSB    = 11;
  localparam int unsigned RN_MSB    = 10;
  localparam int unsigned RN_LSB    = 8;
  localparam int unsigned RD_MSB    = 7;
  localparam int unsigned RD_LSB    = 5;
  localparam int unsigned SH_MSB    = 4;
  localparam int unsigned SH_LSB    = 3;
  localparam int unsigned RM_MSB    = 2;
  localparam int unsigned RM_LSB    = 0;
  localparam int unsigned IMM5_W    = 5;
  localparam int unsigned IMM8_W    = 8;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RM = 3'b010;
  localparam logic [2:0] NSEL_RD = 3'b100;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_FETCH = 5'b00010,
    ST_ISSUE = 5'b00100,
    ST_EXEC  = 5'b01000,
    ST_HALT  = 5'b10000
  } fetch_state_e;

endpackage

// File: rtl/instr_dec.sv
// Combinational IR field extraction, immediate sign extension and the
// nsel-driven register-number mux.
module instr_dec
  import riscm_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  input  logic [2:0]      nsel,
  output logic [2:0]      opcode,
  output logic [1:0]      op,
  output logic [1:0]      shift,
  output logic [2:0]      readnum,
  output logic [2:0]      writenum,
  output logic [IR_W-1:0] sximm5,
  output logic [IR_W-1:0] sximm8
);

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign op     = ir[OP_MSB:OP_LSB];
  assign shift  = ir[SH_MSB:SH_LSB];
  assign sximm5 = {{(IR_W-IMM5_W){ir[IMM5_W-1]}}, ir[IMM5_W-1:0]};
  assign sximm8 = {{(IR_W-IMM8_W){ir[IMM8_W-1]}}, ir[IMM8_W-1:0]};

  // Non-one-hot selects deliberately read as register 0.
  always_comb begin
    readnum = 3'd0;
    case (nsel)
      NSEL_RN: readnum = ir[RN_MSB:RN_LSB];
      NSEL_RM: readnum = ir[RM_MSB:RM_LSB];
      NSEL_RD: readnum = ir[RD_MSB:RD_LSB];
      default: readnum = 3'd0;
    endcase
  end

  assign writenum = readnum;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds PC and IR, fetches over a valid-qualified read and
// hands each instruction to the controller with the s/w handshake.
module instr_fetch_unit
  import riscm_pkg::*;
#(
  parameter int unsigned       PC_W     = 8,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_valid,
  output logic            s,
  input  logic            w,
  input  logic [2:0]      nsel,
  output logic [2:0]      opcode,
  output logic [1:0]      op,
  output logic [1:0]      shift,
  output logic [2:0]      readnum,
  output logic [2:0]      writenum,
  output logic [15:0]     sximm5,
  output logic [15:0]     sximm8,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir,
  output logic            halted
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         ir_load;
  logic         pc_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_valid) begin
          ir_load = 1'b1;
          state_d = (mem_rdata[OPC_MSB:OPC_LSB] == OPC_HALT) ? ST_HALT : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_EXEC;
      // A w already high on the first EXEC cycle retires immediately.
      ST_EXEC: begin
        if (w) begin
          pc_inc  = 1'b1;
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      if (ir_load) ir <= mem_rdata;
      if (pc_inc)  pc <= pc + PC_W'(1);
    end
  end

  // Handshake/status outputs come straight off the one-hot state flops.
  assign mem_rd   = (state_q == ST_FETCH);
  assign s        = (state_q == ST_ISSUE);
  assign halted   = (state_q == ST_HALT);
  assign mem_addr = pc;

  instr_dec u_dec (
    .ir       (ir),
    .nsel     (nsel),
    .opcode   (opcode),
    .op       (op),
    .shift    (shift),
    .readnum  (readnum),
    .writenum (writenum),
    .sximm5   (sximm5),
    .sximm8   (sximm8)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus
// randomized fetch traffic against an instruction-level reference model.
module tb_instr_fetch_unit;

  localparam int unsigned PC_W = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            run = 1'b0;
  logic            mem_valid = 1'b0;
  logic [15:0]     mem_rdata = 16'h0;
  logic            w = 1'b1;
  logic [2:0]      nsel = 3'b000;

  logic [PC_W-1:0] mem_addr, pc;
  logic            mem_rd, s, halted;
  logic [2:0]      opcode, readnum, writenum;
  logic [1:0]      op, shift;
  logic [15:0]     sximm5, sximm8, ir;

  logic [PC_W-1:0] mem_addr_ff, pc_ff;
  logic            mem_rd_ff, s_ff, halted_ff;
  logic [2:0]      opcode_ff, readnum_ff, writenum_ff;
  logic [1:0]      op_ff, shift_ff;
  logic [15:0]     sximm5_ff, sximm8_ff, ir_ff;

  int              vectors = 0;
  int              miscompares = 0;
  logic [PC_W-1:0] exp_pc = '0;
  logic [15:0]     exp_ir = 16'h0;

  instr_fetch_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .s(s), .w(w), .nsel(nsel),
    .opcode(opcode), .op(op), .shift(shift), .readnum(readnum), .writenum(writenum),
    .sximm5(sximm5), .sximm8(sximm8), .pc(pc), .ir(ir), .halted(halted)
  );

  instr_fetch_unit #(.PC_W(PC_W), .RESET_PC(8'hFF)) dut_ff (
    .clk(clk), .reset(reset), .run(run), .mem_addr(mem_addr_ff), .mem_rd(mem_rd_ff),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .s(s_ff), .w(w), .nsel(nsel),
    .opcode(opcode_ff), .op(op_ff), .shift(shift_ff), .readnum(readnum_ff),
    .writenum(writenum_ff), .sximm5(sximm5_ff), .sximm8(sximm8_ff), .pc(pc_ff),
    .ir(ir_ff), .halted(halted_ff)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] p);
    return PC_W'((int'(p) + 1) % (1 << PC_W));
  endfunction

  // One full instruction: fetch with dly wait cycles, controller busy for ctrl cycles.
  task automatic do_instr(input logic [15:0] word, input int dly, input int ctrl);
    int n;
    int sel;
    int v5;
    int v8;
    logic [2:0] ns;
    n = 0;
    while (mem_rd !== 1'b1 && n < 5) begin
      tick();
      n++;
    end
    vectors++;
    if (mem_rd !== 1'b1 || mem_addr !== exp_pc) begin
      miscompares++;
      $display("FAIL fetch_req: mem_rd=%b addr=%h expected mem_rd=1 addr=%h", mem_rd, mem_addr, exp_pc);
    end
    for (int i = 0; i < dly; i++) begin
      mem_rdata = 16'($urandom);
      tick();
      vectors++;
      if (mem_rd !== 1'b1 || s !== 1'b0 || ir !== exp_ir) begin
        miscompares++;
        $display("FAIL fetch_wait: mem_rd=%b s=%b ir=%h expected 1 0 %h", mem_rd, s, ir, exp_ir);
      end
    end
    mem_rdata = word;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    mem_rdata = 16'($urandom);
    exp_ir = word;
    vectors++;
    if (ir !== exp_ir) begin
      miscompares++;
      $display("FAIL ir_latch: ir=%h expected %h", ir, exp_ir);
    end
    if (word[15:13] == 3'b111) begin
      vectors++;
      if (halted !== 1'b1 || s !== 1'b0 || mem_rd !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_entry: halted=%b s=%b mem_rd=%b expected 1 0 0", halted, s, mem_rd);
      end
      return;
    end
    v5 = int'(word) & 31;
    if (v5 > 15) v5 -= 32;
    v8 = int'(word) & 255;
    if (v8 > 127) v8 -= 256;
    vectors++;
    if (opcode !== 3'(int'(word) / 8192) || op !== 2'((int'(word) / 2048) % 4) ||
        shift !== 2'((int'(word) / 8) % 4) || sximm5 !== 16'(v5) || sximm8 !== 16'(v8)) begin
      miscompares++;
      $display("FAIL fields: opc=%b op=%b sh=%b sx5=%h sx8=%h for ir=%h expected %b %b %b %h %h",
               opcode, op, shift, sximm5, sximm8, word, 3'(int'(word) / 8192),
               2'((int'(word) / 2048) % 4), 2'((int'(word) / 8) % 4), 16'(v5), 16'(v8));
    end
    for (int k = 0; k < 2; k++) begin
      ns = 3'($urandom_range(0, 7));
      nsel = ns;
      #1;
      case (ns)
        3'b001:  sel = (int'(word) / 256) % 8;
        3'b010:  sel = int'(word) % 8;
        3'b100:  sel = (int'(word) / 32) % 8;
        default: sel = 0;
      endcase
      vectors++;
      if (readnum !== 3'(sel) || writenum !== 3'(sel)) begin
        miscompares++;
        $display("FAIL regsel: nsel=%b readnum=%0d writenum=%0d expected %0d", ns, readnum, writenum, sel);
      end
    end
    vectors++;
    if (s !== 1'b1 || mem_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL issue: s=%b mem_rd=%b expected s=1 mem_rd=0", s, mem_rd);
    end
    w = (ctrl == 0);
    mem_valid = 1'($urandom_range(0, 1));
    tick();
    vectors++;
    if (s !== 1'b0 || pc !== exp_pc || ir !== exp_ir) begin
      miscompares++;
      $display("FAIL exec_entry: s=%b pc=%h ir=%h expected 0 %h %h", s, pc, ir, exp_pc, exp_ir);
    end
    for (int i = 0; i < ctrl; i++) begin
      mem_valid = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (s !== 1'b0 || mem_rd !== 1'b0 || pc !== exp_pc || ir !== exp_ir) begin
        miscompares++;
        $display("FAIL exec_busy: s=%b mem_rd=%b pc=%h ir=%h expected 0 0 %h %h", s, mem_rd, pc, ir, exp_pc, exp_ir);
      end
    end
    w = 1'b1;
    mem_valid = 1'b0;
    tick();
    exp_pc = next_pc(exp_pc);
    vectors++;
    if (pc !== exp_pc || mem_rd !== run || s !== 1'b0) begin
      miscompares++;
      $display("FAIL retire: pc=%h mem_rd=%b s=%b expected %h %b 0", pc, mem_rd, s, exp_pc, run);
    end
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if (pc !== 8'h00 || ir !== 16'h0 || s !== 1'b0 || mem_rd !== 1'b0 || halted !== 1'b0 ||
        opcode !== 3'b0 || sximm8 !== 16'h0 || pc_ff !== 8'hFF) begin
      miscompares++;
      $display("FAIL %s: pc=%h ir=%h s=%b mem_rd=%b halted=%b opc=%b sx8=%h pc_ff=%h expected 00 0000 0 0 0 000 0000 ff",
               tag, pc, ir, s, mem_rd, halted, opcode, sximm8, pc_ff);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #23;
    check_reset_values("reset_values");
    @(negedge clk);
    reset = 1'b1;
    exp_pc = '0;
    exp_ir = 16'h0;
    tick();
    vectors++;
    if (mem_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_run: mem_rd=%b expected 0", mem_rd);
    end
  endtask

  task automatic test_basic();
    run = 1'b1;
    tick();
    do_instr(16'hA1A2, 0, 2);
    vectors++;
    if (opcode !== 3'b101 || pc !== 8'h01 || pc_ff !== 8'h00) begin
      miscompares++;
      $display("FAIL basic: opcode=%b pc=%h pc_ff=%h expected 101 01 00", opcode, pc, pc_ff);
    end
  endtask

  task automatic test_decode();
    logic [2:0] sels [4];
    logic [2:0] exps [4];
    sels[0] = 3'b001; sels[1] = 3'b010; sels[2] = 3'b100; sels[3] = 3'b011;
    exps[0] = 3'd5;   exps[1] = 3'd3;   exps[2] = 3'd7;   exps[3] = 3'd0;
    do_instr(16'hD5E3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      nsel = sels[i];
      #1;
      vectors++;
      if (readnum !== exps[i] || writenum !== exps[i]) begin
        miscompares++;
        $display("FAIL decode_nsel: nsel=%b readnum=%0d writenum=%0d expected %0d", sels[i], readnum, writenum, exps[i]);
      end
    end
    vectors++;
    if (sximm8 !== 16'hFFE3 || sximm5 !== 16'h0003) begin
      miscompares++;
      $display("FAIL decode_imm: sximm8=%h sximm5=%h expected ffe3 0003", sximm8, sximm5);
    end
  endtask

  task automatic test_mem_delay();
    do_instr(16'h4C3B, 3, 1);
  endtask

  task automatic test_random();
    logic [15:0] word;
    for (int i = 0; i < 40; i++) begin
      word = 16'($urandom);
      if (word[15:13] == 3'b111) word[13] = 1'b0;
      do_instr(word, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_run_drop();
    run = 1'b0;
    do_instr(16'hC0DE, 2, 1);
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (mem_rd !== 1'b0 || s !== 1'b0 || pc !== exp_pc || ir !== exp_ir) begin
        miscompares++;
        $display("FAIL idle_park: mem_rd=%b s=%b pc=%h ir=%h expected 0 0 %h %h", mem_rd, s, pc, ir, exp_pc, exp_ir);
      end
    end
    mem_valid = 1'b0;
    run = 1'b1;
    tick();
    vectors++;
    if (mem_rd !== 1'b1 || mem_addr !== exp_pc) begin
      miscompares++;
      $display("FAIL resume: mem_rd=%b addr=%h expected 1 %h", mem_rd, mem_addr, exp_pc);
    end
  endtask

  task automatic test_reset_mid_exec();
    mem_rdata = 16'hA9F1;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    w = 1'b0;
    tick();
    #3;
    reset = 1'b0;
    #1;
    check_reset_values("reset_mid_exec");
    exp_pc = '0;
    exp_ir = 16'h0;
    @(negedge clk);
    reset = 1'b1;
    w = 1'b1;
    tick();
  endtask

  task automatic test_halt();
    logic [PC_W-1:0] frozen;
    do_instr(16'hE000, 1, 0);
    frozen = exp_pc;
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_valid = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      tick();
      vectors++;
      if (halted !== 1'b1 || s !== 1'b0 || mem_rd !== 1'b0 || pc !== frozen || ir !== 16'hE000) begin
        miscompares++;
        $display("FAIL halt_hold: halted=%b s=%b mem_rd=%b pc=%h ir=%h expected 1 0 0 %h e000",
                 halted, s, mem_rd, pc, ir, frozen);
      end
    end
    mem_valid = 1'b0;
    run = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("halt_exit_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode();
    test_mem_delay();
    test_random();
    test_run_drop();
    test_reset_mid_exec();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
